gemm_tile_sequencer: RTL and testbench

Hardware replacement for the software tiling loop that drives the `gemm` accelerator's system-bus register file. Given one job (M, N, K and the base addresses of A, B and C), it walks the (n, m, k) tile space and, for each tile, writes the seven tile registers. It then polls the accelerator's FULL flag and, after the last tile, polls DONE. It sits between the host/CPU job interface and the `gemm` system-bus slave port.

---
 rtl/gemm_tile_sequencer_pkg.sv | 64 ++++++
 rtl/gemm_tile_sequencer_iter.sv | 105 ++++++++++
 rtl/gemm_tile_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gemm_tile_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gemm_tile_sequencer_pkg
// Shared configuration for the gemm tile sequencer: default systolic-array
// tile sizes, the gemm register offsets, the sequencer state encoding and a
// couple of small helper functions.
// -----------------------------------------------------------------------------
package gemm_tile_sequencer_pkg;

    // Systolic array geometry used as the default N/K tile sizes.
    localparam int SUPER_SYS_ROWS = 4;
    localparam int SUPER_SYS_COLS = 4;

    // gemm register file offsets, relative to the register base.
    localparam logic [31:0] GEMM_REG_TILE_A  = 32'd0;
    localparam logic [31:0] GEMM_REG_TILE_B  = 32'd4;
    localparam logic [31:0] GEMM_REG_TILE_C  = 32'd8;
    localparam logic [31:0] GEMM_REG_ASTRIDE = 32'd12;
    localparam logic [31:0] GEMM_REG_BSTRIDE = 32'd16;
    localparam logic [31:0] GEMM_REG_CTRL    = 32'd20;
    localparam logic [31:0] GEMM_REG_DIM     = 32'd24;

    // Legacy state codes; the enum below reuses them so older tooling that
    // decodes the raw state value keeps working.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CFG    = 3'd1;
    localparam logic [2:0] ST_FREQ   = 3'd2;
    localparam logic [2:0] ST_FCHK   = 3'd3;
    localparam logic [2:0] ST_DREQ   = 3'd4;
    localparam logic [2:0] ST_DCHK   = 3'd5;
    localparam logic [2:0] ST_FINISH = 3'd6;

    typedef enum logic [2:0] {
        SEQ_IDLE   = ST_IDLE,
        SEQ_CFG    = ST_CFG,
        SEQ_FREQ   = ST_FREQ,
        SEQ_FCHK   = ST_FCHK,
        SEQ_DREQ   = ST_DREQ,
        SEQ_DCHK   = ST_DCHK,
        SEQ_FINISH = ST_FINISH
    } gemm_seq_state_e;

    // Register offset written by each configuration step, in issue order.
    function automatic logic [31:0] cfg_reg_offset(input logic [2:0] step);
        logic [31:0] off;
        case (step)
            3'd0:    off = GEMM_REG_ASTRIDE;
            3'd1:    off = GEMM_REG_BSTRIDE;
            3'd2:    off = GEMM_REG_TILE_A;
            3'd3:    off = GEMM_REG_TILE_B;
            3'd4:    off = GEMM_REG_TILE_C;
            3'd5:    off = GEMM_REG_CTRL;
            3'd6:    off = GEMM_REG_DIM;
            default: off = GEMM_REG_TILE_A;
        endcase
        return off;
    endfunction

    // True in the four states that poll the accelerator status.
    function automatic logic is_poll_state(input gemm_seq_state_e st);
        return (st == SEQ_FREQ) || (st == SEQ_FCHK) ||
               (st == SEQ_DREQ) || (st == SEQ_DCHK);
    endfunction

endpackage

// File: rtl/gemm_tile_sequencer_iter.sv
// -----------------------------------------------------------------------------
// gemm_tile_iter
// Walks the (n, m, k) tile space with k innermost and n outermost, and derives
// the per-tile sizes and flags from the current indices.
// Ports: clk, rst (sync active-low), clear (restart at tile 0), advance (step
// to the next tile), m_dim/n_dim/k_dim (latched job dims), m_idx/n_idx/k_idx,
// msize/nsize/ksize, first, last, has_next.
// -----------------------------------------------------------------------------
module gemm_tile_iter
    import gemm_tile_sequencer_pkg::*;
#(
    parameter int BLKN  = SUPER_SYS_ROWS,
    parameter int BLKK  = SUPER_SYS_COLS,
    parameter int BLKM  = 16,
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] m_dim,
    input  logic [DIM_W-1:0] n_dim,
    input  logic [DIM_W-1:0] k_dim,
    output logic [DIM_W-1:0] m_idx,
    output logic [DIM_W-1:0] n_idx,
    output logic [DIM_W-1:0] k_idx,
    output logic [DIM_W-1:0] msize,
    output logic [DIM_W-1:0] nsize,
    output logic [DIM_W-1:0] ksize,
    output logic             first,
    output logic             last,
    output logic             has_next
);

    // One extra bit so index + block size cannot overflow in the compares.
    localparam logic [DIM_W:0] BLKN_C = BLKN[DIM_W:0];
    localparam logic [DIM_W:0] BLKK_C = BLKK[DIM_W:0];
    localparam logic [DIM_W:0] BLKM_C = BLKM[DIM_W:0];

    logic [DIM_W-1:0] m_r, n_r, k_r;
    logic [DIM_W-1:0] m_rem_s, n_rem_s, k_rem_s;
    logic             m_last_s, n_last_s, k_last_s;

    // Remaining extents, edge-tile detection and clipped tile sizes.
    always_comb begin
        m_rem_s  = m_dim - m_r;
        n_rem_s  = n_dim - n_r;
        k_rem_s  = k_dim - k_r;
        m_last_s = ({1'b0, m_r} + BLKM_C) >= {1'b0, m_dim};
        n_last_s = ({1'b0, n_r} + BLKN_C) >= {1'b0, n_dim};
        k_last_s = ({1'b0, k_r} + BLKK_C) >= {1'b0, k_dim};
        if ({1'b0, m_rem_s} > BLKM_C) begin
            msize = BLKM_C[DIM_W-1:0];
        end else begin
            msize = m_rem_s;
        end
        if ({1'b0, n_rem_s} > BLKN_C) begin
            nsize = BLKN_C[DIM_W-1:0];
        end else begin
            nsize = n_rem_s;
        end
        if ({1'b0, k_rem_s} > BLKK_C) begin
            ksize = BLKK_C[DIM_W-1:0];
        end else begin
            ksize = k_rem_s;
        end
    end

    assign m_idx    = m_r;
    assign n_idx    = n_r;
    assign k_idx    = k_r;
    assign first    = (k_r == {DIM_W{1'b0}});
    assign last     = k_last_s;
    assign has_next = !(k_last_s && m_last_s && n_last_s);

    // Tile index counters: k wraps into m, m wraps into n.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_r <= {DIM_W{1'b0}};
            n_r <= {DIM_W{1'b0}};
            k_r <= {DIM_W{1'b0}};
        end else if (clear) begin
            m_r <= {DIM_W{1'b0}};
            n_r <= {DIM_W{1'b0}};
            k_r <= {DIM_W{1'b0}};
        end else if (advance) begin
            if (!k_last_s) begin
                k_r <= k_r + BLKK_C[DIM_W-1:0];
            end else begin
                k_r <= {DIM_W{1'b0}};
                if (!m_last_s) begin
                    m_r <= m_r + BLKM_C[DIM_W-1:0];
                end else begin
                    m_r <= {DIM_W{1'b0}};
                    n_r <= n_r + BLKN_C[DIM_W-1:0];
                end
            end
        end else begin
            m_r <= m_r;
            n_r <= n_r;
            k_r <= k_r;
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// -----------------------------------------------------------------------------
// gemm_tile_sequencer
// Runs one GEMM job on the gemm accelerator: for each (n, m, k) tile it writes
// the seven tile registers, polls FULL at +0, and after the last tile polls
// DONE at +24. All bus outputs are registered and set up one cycle ahead from
// the next-state decode, so the first write appears the cycle after start.
// Ports: clk, rst (sync active-low); job side start, m_dim/n_dim/k_dim,
// a_base/b_base/c_base, busy, done, error, tile_count; bus side bus_en,
// bus_rdwr (1 = write), bus_addr, bus_wr_data, bus_rd_data.
// Optional: define GEMM_SEQ_TIMEOUT_EN to abort polling after POLL_TIMEOUT
// cycles with error set; otherwise polling is unbounded and error stays 0.
// -----------------------------------------------------------------------------
module gemm_tile_sequencer
    import gemm_tile_sequencer_pkg::*;
#(
    parameter int          BLKN         = SUPER_SYS_ROWS,
    parameter int          BLKK         = SUPER_SYS_COLS,
    parameter int          BLKM         = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h9000_0000,
    parameter int          DIM_W        = 16,
    parameter int          POLL_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] m_dim,
    input  logic [DIM_W-1:0] n_dim,
    input  logic [DIM_W-1:0] k_dim,
    input  logic [31:0]      a_base,
    input  logic [31:0]      b_base,
    input  logic [31:0]      c_base,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      tile_count,
    output logic             bus_en,
    output logic             bus_rdwr,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wr_data,
    input  logic [31:0]      bus_rd_data
);

    gemm_seq_state_e  state_r, state_nxt_s;
    logic [2:0]       step_r, step_nxt_s;
    logic             start_acc_s, advance_s, tile_inc_s, timeout_s;
    logic [DIM_W-1:0] m_lat_r, n_lat_r, k_lat_r;
    logic [31:0]      a_base_r, b_base_r, c_base_r;
    logic [DIM_W-1:0] m_idx_s, n_idx_s, k_idx_s, msize_s, nsize_s, ksize_s;
    logic             first_s, last_s, has_next_s;
    logic [31:0]      a_addr_s, b_addr_s, c_addr_s, dim_word_s, k_word_s;
    logic             bus_en_nxt_s, bus_rdwr_nxt_s;
    logic [31:0]      bus_addr_nxt_s, bus_wr_data_nxt_s;
    logic             busy_r, done_r, bus_en_r, bus_rdwr_r;
    logic [31:0]      bus_addr_r, bus_wr_data_r;
    logic [15:0]      tile_count_r;
    logic [30:0]      rd_data_unused_s;

    assign start_acc_s      = (state_r == SEQ_IDLE) && start;
    assign rd_data_unused_s = bus_rd_data[31:1];

    gemm_tile_iter #(
        .BLKN (BLKN),
        .BLKK (BLKK),
        .BLKM (BLKM),
        .DIM_W(DIM_W)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_acc_s),
        .advance (advance_s),
        .m_dim   (m_lat_r),
        .n_dim   (n_lat_r),
        .k_dim   (k_lat_r),
        .m_idx   (m_idx_s),
        .n_idx   (n_idx_s),
        .k_idx   (k_idx_s),
        .msize   (msize_s),
        .nsize   (nsize_s),
        .ksize   (ksize_s),
        .first   (first_s),
        .last    (last_s),
        .has_next(has_next_s)
    );

`ifdef GEMM_SEQ_TIMEOUT_EN
    logic [31:0] poll_cnt_r;
    logic        error_r;

    assign timeout_s = is_poll_state(state_r) && (poll_cnt_r >= 32'(POLL_TIMEOUT));
    assign error     = error_r;

    // Poll cycle counter; cleared whenever the next state is not a poll state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            poll_cnt_r <= 32'd0;
        end else if (is_poll_state(state_nxt_s)) begin
            poll_cnt_r <= poll_cnt_r + 32'd1;
        end else begin
            poll_cnt_r <= 32'd0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            error_r <= 1'b0;
        end else if (start_acc_s) begin
            error_r <= 1'b0;
        end else if (timeout_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end
`else
    logic [31:0] poll_timeout_unused_s;

    assign poll_timeout_unused_s = 32'(POLL_TIMEOUT);
    assign timeout_s             = 1'b0;
    assign error                 = 1'b0;
`endif

    // Tile address arithmetic, 32-bit unsigned with wrap.
    always_comb begin
        a_addr_s   = a_base_r + 32'(k_idx_s) + 32'(m_idx_s) * 32'(k_lat_r);
        b_addr_s   = b_base_r + 32'(n_idx_s)
                   + (32'(k_idx_s) + 32'(ksize_s) - 32'd1) * 32'(n_lat_r);
        c_addr_s   = c_base_r + 32'(n_idx_s) + 32'(m_idx_s) * 32'(n_lat_r);
        dim_word_s = 32'(msize_s) | (32'(ksize_s) << 3'd5) | (32'(nsize_s) << 4'd10);
        // Step 0 is set up while still in IDLE, before K has been latched.
        if (state_r == SEQ_IDLE) begin
            k_word_s = 32'(k_dim);
        end else begin
            k_word_s = 32'(k_lat_r);
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        advance_s   = 1'b0;
        tile_inc_s  = 1'b0;
        if (timeout_s) begin
            state_nxt_s = SEQ_FINISH;
            step_nxt_s  = 3'd0;
        end else begin
            case (state_r)
                SEQ_IDLE: begin
                    if (!start) begin
                        state_nxt_s = SEQ_IDLE;
                    end else if ((m_dim != {DIM_W{1'b0}}) && (n_dim != {DIM_W{1'b0}}) &&
                                 (k_dim != {DIM_W{1'b0}})) begin
                        state_nxt_s = SEQ_CFG;
                        step_nxt_s  = 3'd0;
                    end else begin
                        state_nxt_s = SEQ_FINISH;
                    end
                end
                SEQ_CFG: begin
                    if (step_r == 3'd6) begin
                        state_nxt_s = SEQ_FREQ;
                        step_nxt_s  = 3'd0;
                        tile_inc_s  = 1'b1;
                    end else begin
                        step_nxt_s  = step_r + 3'd1;
                    end
                end
                SEQ_FREQ: state_nxt_s = SEQ_FCHK;
                SEQ_FCHK: begin
                    if (bus_rd_data[0]) begin
                        state_nxt_s = SEQ_FREQ;
                    end else if (has_next_s) begin
                        state_nxt_s = SEQ_CFG;
                        step_nxt_s  = 3'd0;
                        advance_s   = 1'b1;
                    end else begin
                        state_nxt_s = SEQ_DREQ;
                    end
                end
                SEQ_DREQ: state_nxt_s = SEQ_DCHK;
                SEQ_DCHK: begin
                    if (bus_rd_data[0]) begin
                        state_nxt_s = SEQ_FINISH;
                    end else begin
                        state_nxt_s = SEQ_DREQ;
                    end
                end
                SEQ_FINISH: state_nxt_s = SEQ_IDLE;
                default:    state_nxt_s = SEQ_IDLE;
            endcase
        end
    end

    // Bus values for the coming cycle, decoded from the next state and step.
    always_comb begin
        bus_en_nxt_s      = 1'b0;
        bus_rdwr_nxt_s    = 1'b0;
        bus_addr_nxt_s    = 32'd0;
        bus_wr_data_nxt_s = 32'd0;
        case (state_nxt_s)
            SEQ_CFG: begin
                bus_en_nxt_s   = 1'b1;
                bus_rdwr_nxt_s = 1'b1;
                bus_addr_nxt_s = BASE_ADDR + cfg_reg_offset(step_nxt_s);
                case (step_nxt_s)
                    3'd0:    bus_wr_data_nxt_s = k_word_s;
                    3'd1:    bus_wr_data_nxt_s = 32'(n_lat_r);
                    3'd2:    bus_wr_data_nxt_s = a_addr_s;
                    3'd3:    bus_wr_data_nxt_s = b_addr_s;
                    3'd4:    bus_wr_data_nxt_s = c_addr_s;
                    3'd5:    bus_wr_data_nxt_s = {30'd0, first_s, last_s};
                    3'd6:    bus_wr_data_nxt_s = dim_word_s;
                    default: bus_wr_data_nxt_s = 32'd0;
                endcase
            end
            SEQ_FREQ: begin
                bus_en_nxt_s   = 1'b1;
                bus_addr_nxt_s = BASE_ADDR + GEMM_REG_TILE_A;
            end
            SEQ_DREQ: begin
                bus_en_nxt_s   = 1'b1;
                bus_addr_nxt_s = BASE_ADDR + GEMM_REG_DIM;
            end
            default: begin
                bus_en_nxt_s = 1'b0;
            end
        endcase
    end

    // State and configuration step registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= SEQ_IDLE;
            step_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    // Job parameters, captured on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_lat_r  <= {DIM_W{1'b0}};
            n_lat_r  <= {DIM_W{1'b0}};
            k_lat_r  <= {DIM_W{1'b0}};
            a_base_r <= 32'd0;
            b_base_r <= 32'd0;
            c_base_r <= 32'd0;
        end else if (start_acc_s) begin
            m_lat_r  <= m_dim;
            n_lat_r  <= n_dim;
            k_lat_r  <= k_dim;
            a_base_r <= a_base;
            b_base_r <= b_base;
            c_base_r <= c_base;
        end else begin
            m_lat_r  <= m_lat_r;
            n_lat_r  <= n_lat_r;
            k_lat_r  <= k_lat_r;
            a_base_r <= a_base_r;
            b_base_r <= b_base_r;
            c_base_r <= c_base_r;
        end
    end

    // Registered job-status and bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            tile_count_r  <= 16'd0;
            bus_en_r      <= 1'b0;
            bus_rdwr_r    <= 1'b0;
            bus_addr_r    <= 32'd0;
            bus_wr_data_r <= 32'd0;
        end else begin
            busy_r        <= (state_nxt_s != SEQ_IDLE) && (state_nxt_s != SEQ_FINISH);
            done_r        <= (state_nxt_s == SEQ_FINISH);
            bus_en_r      <= bus_en_nxt_s;
            bus_rdwr_r    <= bus_rdwr_nxt_s;
            bus_addr_r    <= bus_addr_nxt_s;
            bus_wr_data_r <= bus_wr_data_nxt_s;
            if (start_acc_s) begin
                tile_count_r <= 16'd0;
            end else if (tile_inc_s) begin
                tile_count_r <= tile_count_r + 16'd1;
            end else begin
                tile_count_r <= tile_count_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign tile_count  = tile_count_r;
    assign bus_en      = bus_en_r;
    assign bus_rdwr    = bus_rdwr_r;
    assign bus_addr    = bus_addr_r;
    assign bus_wr_data = bus_wr_data_r;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gemm_tile_sequencer
// Directed bench for gemm_tile_sequencer with BLKN=BLKK=4, BLKM=16 and bases
// 0/100/200. A small bus model answers FULL/DONE reads one cycle after the
// read and logs every write with its cycle number.
// -----------------------------------------------------------------------------
module tb_gemm_tile_sequencer;

    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] m_dim = 16'd0, n_dim = 16'd0, k_dim = 16'd0;
    logic [31:0] a_base = 32'd0, b_base = 32'd100, c_base = 32'd200;
    logic        busy, done, error, bus_en, bus_rdwr;
    logic [15:0] tile_count;
    logic [31:0] bus_addr, bus_wr_data;
    logic [31:0] bus_rd_data = 32'd0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          full_seen = 0;
    int          full_limit = 0;
    logic        done_resp = 1'b1;
    logic [31:0] wa_q[$], wd_q[$], ra_q[$];
    int          wc_q[$], rc_q[$], dn_q[$];

    always #5 clk = ~clk;

    gemm_tile_sequencer #(
        .BLKN(4), .BLKK(4), .BLKM(16), .BASE_ADDR(BASE), .DIM_W(16), .POLL_TIMEOUT(20)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .m_dim(m_dim), .n_dim(n_dim), .k_dim(k_dim),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy), .done(done), .error(error), .tile_count(tile_count),
        .bus_en(bus_en), .bus_rdwr(bus_rdwr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data)
    );

    // Bus model and monitor: logs writes, reads and done pulses by cycle.
    always @(posedge clk) begin
        if (bus_en) en_cnt <= en_cnt + 1;
        if (bus_en && bus_rdwr) begin
            wa_q.push_back(bus_addr - BASE);
            wd_q.push_back(bus_wr_data);
            wc_q.push_back(cyc);
        end
        if (bus_en && !bus_rdwr) begin
            ra_q.push_back(bus_addr - BASE);
            rc_q.push_back(cyc);
            if (bus_addr == BASE + 32'd24) begin
                bus_rd_data <= {31'd0, done_resp};
            end else begin
                bus_rd_data <= {31'd0, (full_seen < full_limit)};
                full_seen   <= full_seen + 1;
            end
        end else begin
            bus_rd_data <= 32'd0;
        end
        if (done) dn_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, act, act, exp, exp);
        end
    endtask

    // Checks the seven writes of tile t (counted from write index wb).
    task automatic check_tile(input string tag, input int wb, input int t,
                              input logic [31:0] k, input logic [31:0] n,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] ctrl,
                              input logic [31:0] dimw);
        logic [31:0] off[7];
        logic [31:0] dat[7];
        int          idx;
        off = '{32'd12, 32'd16, 32'd0, 32'd4, 32'd8, 32'd20, 32'd24};
        dat = '{k, n, a, b, c, ctrl, dimw};
        idx = wb + t * 7;
        check({tag, "_present"}, 32'(wa_q.size() >= idx + 7), 32'd1);
        if (wa_q.size() >= idx + 7) begin
            for (int j = 0; j < 7; j++) begin
                check($sformatf("%s_off%0d", tag, j), wa_q[idx + j], off[j]);
                check($sformatf("%s_dat%0d", tag, j), wd_q[idx + j], dat[j]);
            end
        end
    endtask

    // Issues one job, optionally pokes start again while busy, waits for done.
    task automatic run_job(input int m, input int n, input int k, input int full_n,
                           input int poke, output int s, output int wb, output int rb,
                           output int db, output logic busy_t1);
        @(negedge clk);
        wb = wa_q.size();
        rb = ra_q.size();
        db = dn_q.size();
        full_limit = full_seen + full_n;
        m_dim = 16'(m); n_dim = 16'(n); k_dim = 16'(k);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start   = 1'b0;
        busy_t1 = busy;
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            m_dim = 16'd7; n_dim = 16'd7; k_dim = 16'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 600 && dn_q.size() == db; i++) @(negedge clk);
        check("done_seen", 32'(dn_q.size() - db), 32'd1);
    endtask

    initial begin
        int   s, wb, rb, db, d;
        logic b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_bus_rdwr", 32'(bus_rdwr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wr_data", bus_wr_data, 32'd0);
        check("rst_tile_count", 32'(tile_count), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single 3x3x3 tile
        run_job(3, 3, 3, 0, 0, s, wb, rb, db, b1);
        check("t1_busy_t1", 32'(b1), 32'd1);
        check("t1_nwrites", 32'(wa_q.size() - wb), 32'd7);
        check("t1_first_wr_cyc", 32'(wc_q[wb]), 32'(s + 1));
        check_tile("t1", wb, 0, 32'd3, 32'd3, 32'd0, 32'd106, 32'd200, 32'd3, 32'd3171);
        check("t1_nreads", 32'(ra_q.size() - rb), 32'd2);
        check("t1_rd0_addr", ra_q[rb], 32'd0);
        check("t1_rd1_addr", ra_q[rb + 1], 32'd24);
        check("t1_done_after_dchk", 32'(dn_q[db]), 32'(rc_q[rb + 1] + 2));
        check("t1_done_cyc", 32'(dn_q[db]), 32'(s + 12));
        check("t1_tile_count", 32'(tile_count), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: K=5 splits into two k tiles
        run_job(3, 3, 5, 0, 0, s, wb, rb, db, b1);
        check("t2_nwrites", 32'(wa_q.size() - wb), 32'd14);
        check_tile("t2a", wb, 0, 32'd5, 32'd3, 32'd0, 32'd109, 32'd200, 32'd2, 32'd3203);
        check_tile("t2b", wb, 1, 32'd5, 32'd3, 32'd4, 32'd112, 32'd200, 32'd1, 32'd3107);
        check("t2_tile2_cyc", 32'(wc_q[wb + 7]), 32'(s + 10));
        check("t2_tile_count", 32'(tile_count), 32'd2);

        // 3: N=6 splits into two n tiles; a second start while busy is ignored
        run_job(3, 6, 3, 0, 5, s, wb, rb, db, b1);
        check_tile("t3a", wb, 0, 32'd3, 32'd6, 32'd0, 32'd112, 32'd200, 32'd3, 32'd4195);
        check_tile("t3b", wb, 1, 32'd3, 32'd6, 32'd0, 32'd116, 32'd204, 32'd3, 32'd2147);
        repeat (5) @(negedge clk);
        check("t3_ndone", 32'(dn_q.size() - db), 32'd1);
        check("t3_nwrites", 32'(wa_q.size() - wb), 32'd14);
        check("t3_tile_count", 32'(tile_count), 32'd2);

        // 4: FULL held for five reads after tile 1
        run_job(3, 3, 5, 5, 0, s, wb, rb, db, b1);
        check("t4_nwrites", 32'(wa_q.size() - wb), 32'd14);
        check("t4_tile2_cyc", 32'(wc_q[wb + 7]), 32'(s + 20));
        check("t4_nreads", 32'(ra_q.size() - rb), 32'd8);
        check_tile("t4b", wb, 1, 32'd5, 32'd3, 32'd4, 32'd112, 32'd200, 32'd1, 32'd3107);

        // 5: zero dimension finishes without bus traffic
        d = en_cnt;
        run_job(3, 3, 0, 0, 0, s, wb, rb, db, b1);
        check("t5_nwrites", 32'(wa_q.size() - wb), 32'd0);
        check("t5_bus_en_cycles", 32'(en_cnt - d), 32'd0);
        check("t5_done_latency", 32'((dn_q[db] - s >= 1) && (dn_q[db] - s <= 2)), 32'd1);
        check("t5_tile_count", 32'(tile_count), 32'd0);

        // 6: reset during CFG step 3
        @(negedge clk);
        m_dim = 16'd3; n_dim = 16'd3; k_dim = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !(bus_en && bus_rdwr && bus_addr == BASE + 32'd4); i++)
            @(negedge clk);
        check("t6_at_step3", bus_addr, BASE + 32'd4);
        rst = 1'b0;
        @(negedge clk);
        check("t6_bus_en", 32'(bus_en), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_state", 32'(dut.state_r), 32'd0);
        check("t6_tile_count", 32'(tile_count), 32'd0);
        rst = 1'b1;
        run_job(3, 3, 3, 0, 0, s, wb, rb, db, b1);
        check_tile("t6r", wb, 0, 32'd3, 32'd3, 32'd0, 32'd106, 32'd200, 32'd3, 32'd3171);
        check("t6r_tile_count", 32'(tile_count), 32'd1);

`ifdef GEMM_SEQ_TIMEOUT_EN
        // FULL stuck at 1: the poll timeout aborts with error
        run_job(3, 3, 3, 1000, 0, s, wb, rb, db, b1);
        check("t7_error", 32'(error), 32'd1);
        check("t7_nwrites", 32'(wa_q.size() - wb), 32'd7);
        run_job(3, 3, 3, 0, 0, s, wb, rb, db, b1);
        check("t7_error_cleared", 32'(error), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
